// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm front end: alarm FSM states seen on
// fsm_state, encoder states driven on enc_state, and sensor bit indices.
package alarm_pkg;

   typedef enum logic [1:0] {
      FSM_OFF       = 2'd0,
      FSM_ARMED     = 2'd1,
      FSM_TRIGGERED = 2'd2,
      FSM_ALARM_ON  = 2'd3
   } alarm_state_e;

   typedef enum logic [1:0] {
      ENC_ENTRY  = 2'd0,
      ENC_WATCH  = 2'd1,
      ENC_WINDOW = 2'd2,
      ENC_SENT   = 2'd3
   } enc_state_e;

   localparam int SENS_DOOR   = 0;
   localparam int SENS_MOTION = 1;
   localparam int SENS_N      = 2;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor line: 2-flop synchroniser, stability counter, and a one-cycle
// pulse on the accepted 0->1 transition of the debounced level.
module sensor_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic rise_o
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Accept a new level only after DEBOUNCE consecutive disagreeing samples.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser and debounce state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/alarm_sensor_encoder.sv
// Alarm front end: keypad code check with lockout, debounced sensor events,
// and registered arm / trigger / confirm strobes for the alarm FSM.
module alarm_sensor_encoder
   import alarm_pkg::*;
#(
   parameter logic [15:0] CODE      = 16'h1234,
   parameter int          DEBOUNCE  = 4,
   parameter int          WINDOW    = 16,
   parameter int          MAX_TRIES = 3,
   parameter int          LOCKOUT   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic [1:0] sensor_raw,
   input  logic [1:0] fsm_state,
   output logic       arm_req,
   output logic       trigger,
   output logic       confirm,
   output logic       locked,
   output logic [1:0] enc_state
);

   localparam int FAIL_W = $clog2(MAX_TRIES + 1);
   localparam int LOCK_W = $clog2(LOCKOUT + 1);
   localparam int WIN_W  = $clog2(WINDOW + 1);

   logic [SENS_N-1:0] ev;

   enc_state_e        state_q, state_d;
   logic [1:0]        digit_cnt_q, digit_cnt_d;
   logic [11:0]       shift_q, shift_d;
   logic [FAIL_W-1:0] fail_q, fail_d;
   logic              locked_q, locked_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
   logic [1:0]        mask_q, mask_d;
   logic              arm_q, arm_d;
   logic              trig_q, trig_d;
   logic              conf_q, conf_d;

   for (genvar g = 0; g < SENS_N; g++) begin : g_sens
      sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .raw_i  (sensor_raw[g]),
         .rise_o (ev[g])
      );
   end

   // Next-state logic: lockout countdown, keypad entry and sensor sequencing.
   always_comb begin
      state_d     = state_q;
      digit_cnt_d = digit_cnt_q;
      shift_d     = shift_q;
      fail_d      = fail_q;
      locked_d    = locked_q;
      lock_cnt_d  = lock_cnt_q;
      win_cnt_d   = win_cnt_q;
      mask_d      = mask_q;
      arm_d       = 1'b0;
      trig_d      = 1'b0;
      conf_d      = 1'b0;

      if (locked_q) begin
         if (lock_cnt_q <= LOCK_W'(1)) begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
            fail_d     = '0;
         end else begin
            lock_cnt_d = lock_cnt_q - 1'b1;
         end
      end

      case (state_q)
         ENC_ENTRY: begin
            if (key_valid && !locked_q) begin
               if (key_digit > 4'd9) begin
                  // A non-decimal key abandons the current attempt without penalty.
                  digit_cnt_d = '0;
                  shift_d     = '0;
               end else if (digit_cnt_q == 2'd3) begin
                  digit_cnt_d = '0;
                  shift_d     = '0;
                  if ({shift_q, key_digit} == CODE) begin
                     arm_d   = 1'b1;
                     fail_d  = '0;
                     state_d = ENC_WATCH;
                  end else begin
                     fail_d = fail_q + 1'b1;
                     if (fail_q + 1'b1 == FAIL_W'(MAX_TRIES)) begin
                        locked_d   = 1'b1;
                        lock_cnt_d = LOCK_W'(LOCKOUT);
                     end
                  end
               end else begin
                  shift_d     = {shift_q[7:0], key_digit};
                  digit_cnt_d = digit_cnt_q + 2'd1;
               end
            end
         end
         ENC_WATCH: begin
            if (|ev) begin
               trig_d    = 1'b1;
               mask_d    = ev;
               win_cnt_d = WIN_W'(WINDOW);
               state_d   = ENC_WINDOW;
            end
         end
         ENC_WINDOW: begin
            // Both sensors already fired together: confirm right away.
            if ((|(ev & ~mask_q)) || (mask_q == 2'b11)) begin
               conf_d    = 1'b1;
               mask_d    = '0;
               win_cnt_d = '0;
               state_d   = ENC_SENT;
            end else if (win_cnt_q <= WIN_W'(1)) begin
               mask_d    = '0;
               win_cnt_d = '0;
               state_d   = ENC_WATCH;
            end else begin
               win_cnt_d = win_cnt_q - 1'b1;
            end
         end
         ENC_SENT: begin
            if (fsm_state == FSM_OFF) begin
               digit_cnt_d = '0;
               shift_d     = '0;
               state_d     = ENC_ENTRY;
            end
         end
         default: state_d = ENC_ENTRY;
      endcase
   end

   // State and strobe registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ENC_ENTRY;
         digit_cnt_q <= '0;
         shift_q     <= '0;
         fail_q      <= '0;
         locked_q    <= 1'b0;
         lock_cnt_q  <= '0;
         win_cnt_q   <= '0;
         mask_q      <= '0;
         arm_q       <= 1'b0;
         trig_q      <= 1'b0;
         conf_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         digit_cnt_q <= digit_cnt_d;
         shift_q     <= shift_d;
         fail_q      <= fail_d;
         locked_q    <= locked_d;
         lock_cnt_q  <= lock_cnt_d;
         win_cnt_q   <= win_cnt_d;
         mask_q      <= mask_d;
         arm_q       <= arm_d;
         trig_q      <= trig_d;
         conf_q      <= conf_d;
      end
   end

   assign arm_req   = arm_q;
   assign trigger   = trig_q;
   assign confirm   = conf_q;
   assign locked    = locked_q;
   assign enc_state = state_q;

endmodule

// File: tb/tb_alarm_sensor_encoder.sv
// Directed bench for alarm_sensor_encoder: stimulus queues expected strobes
// (kind and cycle), a monitor pops and compares every strobe the DUT emits.
module tb_alarm_sensor_encoder;
   import alarm_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic [1:0] sensor_raw = 2'b00;
   logic [1:0] fsm_state = 2'd1;
   logic       arm_req, trigger, confirm, locked;
   logic [1:0] enc_state;

   alarm_sensor_encoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_digit  (key_digit),
      .sensor_raw (sensor_raw),
      .fsm_state  (fsm_state),
      .arm_req    (arm_req),
      .trigger    (trigger),
      .confirm    (confirm),
      .locked     (locked),
      .enc_state  (enc_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] kind;
      int         cyc;
   } exp_t;

   localparam logic [2:0] K_ARM  = 3'b001;
   localparam logic [2:0] K_TRIG = 3'b010;
   localparam logic [2:0] K_CONF = 3'b100;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
   endtask

   task automatic push(input logic [2:0] k, input int c);
      exp_t e;
      e.kind = k;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      @(negedge clk);
      key_valid = 1'b0;
      key_digit = 4'd0;
   endtask

   task automatic enter_code(input logic [15:0] code, input bit arms);
      int c0;
      c0 = cyc;
      if (arms) push(K_ARM, c0 + 4);
      for (int i = 0; i < 4; i++) press(code[15-4*i -: 4]);
   endtask

   // Strobe monitor: every strobe cycle must match the next queued expectation.
   always @(negedge clk) begin
      logic [2:0] k;
      exp_t       e;
      k = {confirm, trigger, arm_req};
      if (k != 3'b000) begin
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_strobe: got kind %b at cycle %0d, expected none", k, cyc);
         end else begin
            e = sb.pop_front();
            if (k == e.kind && cyc == e.cyc) n_pass++;
            else $display("FAIL strobe: got kind %b at cycle %0d, expected kind %b at cycle %0d",
                          k, cyc, e.kind, e.cyc);
         end
      end
   end

   initial begin
      int c;

      // Reset state
      tick(3);
      check("reset_outputs", {arm_req, trigger, confirm, locked}, 0);
      check("reset_state", enc_state, ENC_ENTRY);
      rst_n = 1'b1;
      tick(2);

      // Aborted entry followed by the correct code
      press(4'd1);
      press(4'd2);
      press(4'hA);
      enter_code(16'h1234, 1'b1);
      check("armed_watch", enc_state, ENC_WATCH);
      tick(2);

      // Short door glitch is filtered, a held door rise triggers after 7 cycles
      sensor_raw[0] = 1'b1;
      tick(3);
      sensor_raw[0] = 1'b0;
      tick(12);
      check("glitch_no_trigger", enc_state, ENC_WATCH);
      c = cyc;
      push(K_TRIG, c + 7);
      sensor_raw[0] = 1'b1;
      tick(10);
      sensor_raw[0] = 1'b0;
      tick(12);
      check("window_last_cycle", enc_state, ENC_WINDOW);
      tick(1);
      check("window_expired", enc_state, ENC_WATCH);

      // Door then motion 10 cycles later: trigger then confirm
      c = cyc;
      push(K_TRIG, c + 7);
      push(K_CONF, c + 17);
      sensor_raw[0] = 1'b1;
      tick(10);
      sensor_raw[1] = 1'b1;
      tick(7);
      check("confirm_sent", enc_state, ENC_SENT);
      tick(3);
      check("sent_holds", enc_state, ENC_SENT);
      sensor_raw = 2'b00;
      tick(10);
      fsm_state = 2'd0;
      tick(1);
      check("sent_to_entry", enc_state, ENC_ENTRY);
      fsm_state = 2'd1;

      // Motion 20 cycles after door: window expires, motion re-triggers
      enter_code(16'h1234, 1'b1);
      tick(2);
      c = cyc;
      push(K_TRIG, c + 7);
      push(K_TRIG, c + 27);
      sensor_raw[0] = 1'b1;
      tick(20);
      sensor_raw[1] = 1'b1;
      tick(2);
      check("late_window_open", enc_state, ENC_WINDOW);
      tick(1);
      check("late_window_expired", enc_state, ENC_WATCH);
      tick(4);
      check("retrigger_window", enc_state, ENC_WINDOW);
      sensor_raw = 2'b00;
      tick(15);
      check("retrigger_window_end", enc_state, ENC_WINDOW);
      tick(1);
      check("retrigger_expired", enc_state, ENC_WATCH);

      // Both sensors together: trigger at N+1, confirm at N+2
      c = cyc;
      push(K_TRIG, c + 7);
      push(K_CONF, c + 8);
      sensor_raw = 2'b11;
      tick(7);
      check("both_window", enc_state, ENC_WINDOW);
      tick(1);
      check("both_sent", enc_state, ENC_SENT);
      sensor_raw = 2'b00;
      tick(10);
      fsm_state = 2'd0;
      tick(1);
      check("both_to_entry", enc_state, ENC_ENTRY);
      fsm_state = 2'd1;

      // Reset mid-window discards the pending confirm
      enter_code(16'h1234, 1'b1);
      tick(2);
      c = cyc;
      push(K_TRIG, c + 7);
      sensor_raw[0] = 1'b1;
      tick(8);
      sensor_raw[1] = 1'b1;
      tick(2);
      rst_n = 1'b0;
      tick(1);
      check("midrst_outputs", {arm_req, trigger, confirm, locked}, 0);
      check("midrst_state", enc_state, ENC_ENTRY);
      tick(1);
      rst_n = 1'b1;
      tick(20);
      sensor_raw = 2'b00;
      tick(10);
      check("post_rst_state", enc_state, ENC_ENTRY);

      // Three wrong codes lock the keypad for 32 cycles
      c = cyc;
      enter_code(16'h1235, 1'b0);
      check("one_miss_unlocked", locked, 0);
      enter_code(16'h1235, 1'b0);
      enter_code(16'h1235, 1'b0);
      check("locked_after_three", locked, 1);
      enter_code(16'h1234, 1'b0);
      check("locked_ignores_code", enc_state, ENC_ENTRY);
      tick(c + 43 - cyc);
      check("locked_last_cycle", locked, 1);
      tick(1);
      check("unlocked", locked, 0);
      enter_code(16'h1234, 1'b1);
      check("arm_after_lockout", enc_state, ENC_WATCH);

      tick(5);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
